// File: rtl/led_fade_pwm_pkg.sv
// led_pkg: shared widths and constants for the LED fade/PWM block.
// Build option: LED_FADE_PWM_GAMMA_EN enables the squared-level gamma map.
package led_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  localparam level_t LEVEL_MAX = '1;

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern/brightness in, PWM LED drive and period sync out.
// master = pattern source side, slave = led_fade_pwm.
interface led_fade_pwm_if #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8
);

  logic [N_LEDS-1:0]   pattern_in;
  logic [PWM_BITS-1:0] brightness;
  logic [N_LEDS-1:0]   led_out;
  logic                pwm_sync;

  modport master (
    output pattern_in,
    output brightness,
    input  led_out,
    input  pwm_sync
  );

  modport slave (
    input  pattern_in,
    input  brightness,
    output led_out,
    output pwm_sync
  );

endinterface

// File: rtl/led_fade_pwm_channel.sv
// led_pwm_channel: one LED's fade level, duty shadow and PWM compare.
// Build option: LED_FADE_PWM_GAMMA_EN maps duty = level^2 >> PWM_BITS,
// registered one cycle ahead of the shadow load; otherwise duty = level.
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic                load,
  input  logic                pat,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                led
);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_src;

  // Move one unit toward the target; cannot overshoot or wrap.
  function automatic logic [PWM_BITS-1:0] fade_step(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  assign target = pat ? brightness : '0;

  // Fade level: advances only on prescaler steps.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else if (step) level <= fade_step(level, target);
  end

`ifdef LED_FADE_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  logic [PWM_BITS-1:0]   gamma_p1;

  assign level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};

  // Gamma stage: squared level, upper half kept.
  always_ff @(posedge clk) begin
    if (rst) gamma_p1 <= '0;
    else     gamma_p1 <= PWM_BITS'(level_sq >> PWM_BITS);
  end

  assign duty_src = gamma_p1;
`else
  assign duty_src = level;
`endif

  // Duty shadow: updated only on the last count of a period.
  always_ff @(posedge clk) begin
    if (rst)       duty <= '0;
    else if (load) duty <= duty_src;
  end

  // PWM compare, registered to keep the pin glitch free.
  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else     led <= (cnt < duty);
  end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: fades each LED toward its on/off target and renders it as PWM.
// Shared PWM counter, fade prescaler, pattern register and period sync live
// here; per-LED state lives in led_pwm_channel.
// Build option: LED_FADE_PWM_GAMMA_EN (see led_pwm_channel).
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = 19531
) (
  input  logic           clk,
  input  logic           rst,
  led_fade_pwm_if.slave  bus
);

  localparam int                  PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] cnt;
  logic [PRE_W-1:0]    presc;
  logic [N_LEDS-1:0]   pat_q;
  logic [N_LEDS-1:0]   led_bits;
  logic                pwm_sync_q;
  logic                step;
  logic                load;

  assign step = (presc == PRE_LAST);
  assign load = (cnt == CNT_LAST);

  // Shared timing: PWM counter, fade prescaler, sync pulse, pattern register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      presc      <= '0;
      pwm_sync_q <= 1'b0;
      pat_q      <= '0;
    end else begin
      cnt        <= cnt + 1'b1;
      presc      <= step ? '0 : presc + 1'b1;
      pwm_sync_q <= (cnt == '0);
      pat_q      <= bus.pattern_in;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .load       (load),
      .pat        (pat_q[i]),
      .brightness (bus.brightness),
      .cnt        (cnt),
      .led        (led_bits[i])
    );
  end

  assign bus.led_out  = led_bits;
  assign bus.pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with FADE_DIV=4, PWM_BITS=8.
// Reference model counts clock edges since reset and derives the PWM phase,
// fade steps and period boundaries from that count.
module tb_led_fade_pwm;

  localparam int N  = 8;
  localparam int PB = 8;
  localparam int FD = 4;
  localparam int PERIOD = 1 << PB;

`ifdef LED_FADE_PWM_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  led_fade_pwm_if #(.N_LEDS(N), .PWM_BITS(PB)) bus ();

  led_fade_pwm #(
    .N_LEDS   (N),
    .PWM_BITS (PB),
    .FADE_DIV (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  int     m_k;
  int     m_lvl [N];
  int     m_duty[N];
  int     m_g   [N];
  bit [N-1:0] m_pat;
  bit [N-1:0] m_led;
  bit     m_sync;
  int     m_phase;
  int     m_tgt;

  function automatic int gam(input int l);
    return (l * l) >> PB;
  endfunction

  function automatic int exp_hi(input int lvl);
    return GAMMA ? gam(lvl) : lvl;
  endfunction

  // Model: advance one clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_pat = '0; m_led = '0; m_sync = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0; m_duty[i] = 0; m_g[i] = 0;
      end
    end else begin
      m_phase = m_k % PERIOD;
      m_sync  = (m_phase == 0);
      for (int i = 0; i < N; i++) begin
        m_led[i] = (m_phase < m_duty[i]);
        if (m_phase == PERIOD - 1) m_duty[i] = GAMMA ? m_g[i] : m_lvl[i];
        m_g[i] = gam(m_lvl[i]);
        if ((m_k % FD) == FD - 1) begin
          m_tgt = m_pat[i] ? int'(bus.brightness) : 0;
          if (m_lvl[i] < m_tgt) m_lvl[i]++;
          else if (m_lvl[i] > m_tgt) m_lvl[i]--;
        end
      end
      m_pat = bus.pattern_in;
      m_k++;
    end
  end

  bit cmp_en = 1'b0;
  bit glitch_en = 1'b0;
  logic [N-1:0] prev_led = '0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_chk++;
      if (bus.led_out !== m_led || bus.pwm_sync !== m_sync) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: led_out=%h sync=%b, expected led_out=%h sync=%b",
                 $time, bus.led_out, bus.pwm_sync, m_led, m_sync);
      end
    end
  end

  // A rising LED edge is only legal at the start of a PWM period.
  always @(negedge clk) begin
    if (glitch_en) begin
      n_chk++;
      if (|(bus.led_out & ~prev_led) && !bus.pwm_sync) begin
        n_fail++;
        $display("FAIL mid_period_edge t=%0t: led_out=%h prev=%h sync=%b, expected no rise without sync",
                 $time, bus.led_out, prev_led, bus.pwm_sync);
      end
    end
    prev_led = bus.led_out;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hi[N];

  // Find the next sync pulse, then count high cycles per LED over one period.
  task automatic period();
    bit ok;
    ok = 1'b0;
    for (int j = 0; j < 2 * PERIOD + 8; j++) begin
      @(negedge clk);
      if (bus.pwm_sync === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("sync_found", int'(ok), 1);
    for (int i = 0; i < N; i++) hi[i] = 0;
    for (int j = 0; j < PERIOD; j++) begin
      if (j > 0) @(negedge clk);
      for (int i = 0; i < N; i++) hi[i] += int'(bus.led_out[i]);
    end
  endtask

  initial begin
    bus.pattern_in = '0;
    bus.brightness = '0;
    rst = 1'b1;

    // Reset held for 20 cycles: outputs quiet.
    @(negedge clk);
    cmp_en = 1'b1;
    cyc(19);
    check("reset_led_out", int'(bus.led_out), 0);
    check("reset_pwm_sync", int'(bus.pwm_sync), 0);

    // Full fade up of LED0 at brightness 255: 255 steps, one per 4 cycles.
    rst = 1'b0;
    bus.brightness = 8'd255;
    bus.pattern_in = 8'h01;
    cyc(1012);
    check("model_lvl_253", m_lvl[0], 253);
    cyc(7);
    check("model_lvl_254", m_lvl[0], 254);
    cyc(1);
    check("model_lvl_255", m_lvl[0], 255);
    period();
    check("full_on_hi0", hi[0], GAMMA ? 254 : 255);
    check("others_dark", hi[1] + hi[2] + hi[3] + hi[4] + hi[5] + hi[6] + hi[7], 0);

    // Fade back down to dark.
    bus.pattern_in = 8'h00;
    cyc(255 * FD + 600);
    period();
    check("faded_out_hi0", hi[0], 0);

    // All LEDs at brightness 64, then retarget to 32 with edge checking.
    bus.pattern_in = 8'hFF;
    bus.brightness = 8'd64;
    cyc(64 * FD + 600);
    period();
    for (int i = 0; i < N; i++) check($sformatf("b64_hi%0d", i), hi[i], exp_hi(64));
    glitch_en = 1'b1;
    bus.brightness = 8'd32;
    cyc(32 * FD + 600);
    period();
    glitch_en = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("b32_hi%0d", i), hi[i], exp_hi(32));

    // Level 128 on all LEDs.
    bus.brightness = 8'd128;
    cyc(96 * FD + 600);
    period();
    check("b128_hi0", hi[0], GAMMA ? 64 : 128);
    check("b128_hi7", hi[7], GAMMA ? 64 : 128);

    // LED0 at level 100, then reset mid-period.
    bus.pattern_in = 8'h01;
    bus.brightness = 8'd100;
    cyc(28 * FD + 600);
    period();
    check("b100_hi0", hi[0], exp_hi(100));
    cyc(37);
    rst = 1'b1;
    cyc(1);
    check("rst_led_out", int'(bus.led_out), 0);
    check("rst_pwm_sync", int'(bus.pwm_sync), 0);
    cyc(2);
    rst = 1'b0;
    // First period after release: duty still 0. Second: 63 steps taken.
    period();
    check("post_rst_p1_hi0", hi[0], 0);
    period();
    check("post_rst_p2_hi0", hi[0], exp_hi(63));

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
